// File: rtl/cpu_mem_responder_if.sv
// CPU-side request/response bus for cpu_mem_responder.
interface cpu_mem_responder_if;
  logic       req;
  logic       we;
  logic [7:0] bus_in;
  logic [1:0] wait_cfg;
  logic [7:0] bus_out;
  logic [7:0] bus_oe;
  logic       ack;
  logic       busy;

  modport master (output req, we, bus_in, wait_cfg, input bus_out, bus_oe, ack, busy);
  modport slave  (input req, we, bus_in, wait_cfg, output bus_out, bus_oe, ack, busy);
endinterface

// File: rtl/cpu_mem_responder.sv
// Small byte memory answering CPU read/write requests with a one-cycle ack.
// Optional wait states are built only when WAIT_STATE_EN is defined.
module cpu_mem_responder #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  cpu_mem_responder_if.slave cpu
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  if (MAX_WAIT > 3) begin : g_max_wait_check
    $error("MAX_WAIT does not fit the 2-bit wait counter");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_RESP
`ifdef WAIT_STATE_EN
    , S_WAIT
`endif
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_c;
  logic                ack_q;
  logic                busy_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   oe_q;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef WAIT_STATE_EN
  localparam int unsigned        CNT_W = 2;
  localparam logic [CNT_W-1:0]   MAX_W = CNT_W'(MAX_WAIT);
  logic [CNT_W-1:0]              wait_q;
  logic [CNT_W-1:0]              wait_c;
  logic                          write_q;

  assign wait_c = (cpu.wait_cfg > MAX_W) ? MAX_W : cpu.wait_cfg;
`endif

  // High address bits are dropped so addresses wrap.
  assign addr_c = cpu.bus_in[ADDR_W-1:0];

  assign cpu.ack     = ack_q;
  assign cpu.busy    = busy_q;
  assign cpu.bus_out = rdata_q;
  assign cpu.bus_oe  = oe_q;

  // Outputs are loaded on entry to RESP so they are valid for exactly that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
      oe_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
`ifdef WAIT_STATE_EN
      wait_q  <= '0;
      write_q <= 1'b0;
`endif
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      oe_q    <= '0;
      case (state)
        S_IDLE: begin
          if (cpu.req) begin
            addr_q <= addr_c;
            busy_q <= 1'b1;
`ifdef WAIT_STATE_EN
            wait_q  <= wait_c;
            write_q <= cpu.we;
`endif
            if (cpu.we) begin
              state <= S_WDATA;
            end
`ifdef WAIT_STATE_EN
            else if (wait_c != '0) begin
              state <= S_WAIT;
            end
`endif
            else begin
              state   <= S_RESP;
              ack_q   <= 1'b1;
              rdata_q <= mem[addr_c];
              oe_q    <= '1;
            end
          end
        end
        S_WDATA: begin
          mem[addr_q] <= cpu.bus_in;
`ifdef WAIT_STATE_EN
          if (wait_q != '0) begin
            state <= S_WAIT;
          end else
`endif
          begin
            state <= S_RESP;
            ack_q <= 1'b1;
          end
        end
`ifdef WAIT_STATE_EN
        S_WAIT: begin
          wait_q <= wait_q - CNT_W'(1);
          if (wait_q == CNT_W'(1)) begin
            state <= S_RESP;
            ack_q <= 1'b1;
            if (!write_q) begin
              rdata_q <= mem[addr_q];
              oe_q    <= '1;
            end
          end
        end
`endif
        S_RESP: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: vector table, random traffic and
// hand-written corner sequences, with a per-cycle scoreboard monitor.
module tb_cpu_mem_responder;
  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_mem_responder_if m ();

  cpu_mem_responder #(.ADDR_W(AW), .MAX_WAIT(3)) dut (
    .clk (clk),
    .rst (rst),
    .cpu (m)
  );

  typedef struct {
    int unsigned at;
    logic        rd;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic       we;
    logic [7:0] bin;
    logic [7:0] wdata;
    logic [1:0] cfg;
    logic [7:0] exp;
  } vec_t;

  exp_t        sb[$];
  logic [7:0]  mem_model [16];
  int unsigned cyc = 0;
  int unsigned busy_from = 0;
  int unsigned busy_until = 0;
  bit          mon_en = 1'b0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endfunction

  function automatic int unsigned eff_w(input logic [1:0] cfg);
`ifdef WAIT_STATE_EN
    return (cfg > 2'd3) ? 3 : int'(cfg);
`else
    return (cfg == 2'd0) ? 0 : 0;
`endif
  endfunction

  // Every cycle: ack/data only where the scoreboard expects it, busy inside the window.
  always @(negedge clk) begin
    if (mon_en) begin
      logic       e_ack;
      logic [7:0] e_out, e_oe;
      logic       e_busy;
      e_ack = 1'b0; e_out = 8'h00; e_oe = 8'h00;
      if (sb.size() > 0 && sb[0].at == cyc) begin
        exp_t e;
        e = sb.pop_front();
        e_ack = 1'b1;
        if (e.rd) begin
          e_out = e.data;
          e_oe  = 8'hFF;
        end
      end
      e_busy = (cyc >= busy_from) && (cyc <= busy_until);
      check("ack",     32'(m.ack),     32'(e_ack));
      check("bus_out", 32'(m.bus_out), 32'(e_out));
      check("bus_oe",  32'(m.bus_oe),  32'(e_oe));
      check("busy",    32'(m.busy),    32'(e_busy));
    end
  end

  task automatic do_txn(input logic we_i, input logic [7:0] bin, input logic [7:0] wdata,
                        input logic [1:0] cfg, input logic [7:0] exp_d);
    int unsigned t0, ack_c;
    t0    = cyc;
    ack_c = t0 + (we_i ? 2 : 1) + eff_w(cfg);
    sb.push_back('{at: ack_c, rd: !we_i, data: exp_d});
    busy_from  = t0 + 1;
    busy_until = ack_c;
    if (we_i) mem_model[bin[3:0]] = wdata;
    m.req = 1'b1; m.we = we_i; m.bus_in = bin; m.wait_cfg = cfg;
    @(posedge clk); #1;
    m.req = 1'b0; m.we = 1'($urandom); m.wait_cfg = 2'($urandom);
    m.bus_in = we_i ? wdata : 8'($urandom);
    while (cyc < ack_c + 1) begin
      @(posedge clk); #1;
      m.bus_in = 8'($urandom);
    end
  endtask

  vec_t vt[10];

  initial begin
    vt[0] = '{we: 1'b0, bin: 8'h05, wdata: 8'h00, cfg: 2'd0, exp: 8'h00};
    vt[1] = '{we: 1'b1, bin: 8'h03, wdata: 8'hA5, cfg: 2'd0, exp: 8'h00};
    vt[2] = '{we: 1'b0, bin: 8'h03, wdata: 8'h00, cfg: 2'd0, exp: 8'hA5};
    vt[3] = '{we: 1'b1, bin: 8'hF7, wdata: 8'h3C, cfg: 2'd0, exp: 8'h00};
    vt[4] = '{we: 1'b0, bin: 8'h07, wdata: 8'h00, cfg: 2'd0, exp: 8'h3C};
    vt[5] = '{we: 1'b0, bin: 8'h03, wdata: 8'h00, cfg: 2'd2, exp: 8'hA5};
    vt[6] = '{we: 1'b1, bin: 8'h13, wdata: 8'h5A, cfg: 2'd1, exp: 8'h00};
    vt[7] = '{we: 1'b0, bin: 8'h03, wdata: 8'h00, cfg: 2'd3, exp: 8'h5A};
    vt[8] = '{we: 1'b1, bin: 8'h0F, wdata: 8'hFF, cfg: 2'd3, exp: 8'h00};
    vt[9] = '{we: 1'b0, bin: 8'hFF, wdata: 8'h00, cfg: 2'd1, exp: 8'hFF};

    for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
    m.req = 1'b0; m.we = 1'b0; m.bus_in = 8'h00; m.wait_cfg = 2'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++)
      do_txn(vt[i].we, vt[i].bin, vt[i].wdata, vt[i].cfg, vt[i].exp);

    // Random traffic against the memory model.
    for (int i = 0; i < 24; i++) begin
      logic       w;
      logic [7:0] b, d;
      logic [1:0] c;
      w = 1'($urandom); b = 8'($urandom); d = 8'($urandom); c = 2'($urandom);
      do_txn(w, b, d, c, mem_model[b[3:0]]);
    end

    // req held high: one ack per accepted request, RESP-cycle req ignored.
    begin
      int unsigned t0, w, a1, a2;
      t0 = cyc; w = eff_w(2'd1);
      a1 = t0 + 1 + w;
      a2 = a1 + 2 + w;
      sb.push_back('{at: a1, rd: 1'b1, data: mem_model[5]});
      sb.push_back('{at: a2, rd: 1'b1, data: mem_model[5]});
      busy_from = t0 + 1; busy_until = a1;
      m.req = 1'b1; m.we = 1'b0; m.bus_in = 8'h25; m.wait_cfg = 2'd1;
      while (cyc < a1 + 1) begin @(posedge clk); #1; end
      busy_from = a1 + 2; busy_until = a2;
      @(posedge clk); #1;
      m.req = 1'b0;
      while (cyc < a2 + 1) begin @(posedge clk); #1; end
    end

    // Reset in the WDATA cycle aborts the write; reset beats a same-cycle req.
    do_txn(1'b1, 8'h09, 8'h77, 2'd0, 8'h00);
    begin
      int unsigned t0;
      t0 = cyc;
      busy_from = t0 + 1; busy_until = t0 + 1;
      m.req = 1'b1; m.we = 1'b1; m.bus_in = 8'h09; m.wait_cfg = 2'd0;
      @(posedge clk); #1;
      rst = 1'b1; m.req = 1'b0; m.bus_in = 8'h55;
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
      m.req = 1'b1; m.we = 1'b0; m.bus_in = 8'h09;
      @(posedge clk); #1;
      rst = 1'b0; m.req = 1'b0;
    end
    do_txn(1'b0, 8'h09, 8'h00, 2'd0, 8'h00);
    do_txn(1'b0, 8'h03, 8'h00, 2'd0, 8'h00);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
